// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared types and constants for the pong game-control block:
//             the game state encoding and the BCD digit type.
//  Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

   typedef enum logic [1:0] {
      NEWGAME = 2'd0,
      PLAY    = 2'd1,
      NEWBALL = 2'd2,
      OVER    = 2'd3
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t DIGIT_MAX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd2_counter
//  Purpose  : Two-digit BCD up-counter; 99 wraps to 00 with no carry out.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset (clears to 00)
//             clr    - synchronous clear to 00, takes priority over inc
//             inc    - increment by one
//             dig_1  - BCD tens digit
//             dig_0  - BCD units digit
//  Revision : 1.0  initial release
// ============================================================================
module bcd2_counter
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output bcd_digit_t dig_1,
   output bcd_digit_t dig_0
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_1 <= '0;
         dig_0 <= '0;
      end else if (clr) begin
         dig_1 <= '0;
         dig_0 <= '0;
      end else if (inc) begin
         // Compare with >= so a digit can never step past 9.
         if (dig_0 >= DIGIT_MAX) begin
            dig_0 <= '0;
            if (dig_1 >= DIGIT_MAX)
               dig_1 <= '0;
            else
               dig_1 <= dig_1 + 4'd1;
         end else begin
            dig_0 <= dig_0 + 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Game sequencer for pong: new-game / play / new-ball / game-over
//             phases, ball counter, frame-tick hold timer and BCD score.
//  Ports    : clk            - system clock (pixel-clock domain)
//             rst_n          - asynchronous active-low reset
//             refr_tick      - one-cycle pulse per frame
//             btn[1:0]       - debounced paddle buttons (level)
//             hit            - ball struck paddle (pulse)
//             miss           - ball passed paddle (pulse)
//             score_dig_1/0  - BCD score tens / units
//             balls_left_dig - balls remaining
//             graph_still    - ball frozen (state != PLAY)
//             show_rules     - state == NEWGAME
//             show_game_over - state == OVER
//             game_state     - encoded current state
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int BALLS_INIT   = 3,
   parameter int TIMER_FRAMES = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refr_tick,
   input  logic [1:0] btn,
   input  logic       hit,
   input  logic       miss,
   output bcd_digit_t score_dig_1,
   output bcd_digit_t score_dig_0,
   output logic [1:0] balls_left_dig,
   output logic       graph_still,
   output logic       show_rules,
   output logic       show_game_over,
   output logic [1:0] game_state
);

   localparam int TIMER_W = $clog2(TIMER_FRAMES + 1);

   game_state_t        state;
   game_state_t        state_next;
   logic [TIMER_W-1:0] timer;
   logic               timer_done;
   logic               btn_any;
   logic               timer_load;
   logic               ball_dec;
   logic               ball_reload;
   logic               score_inc;
   logic               score_clr;

   assign timer_done = (timer == '0);
   assign btn_any    = |btn;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= NEWGAME;
      else
         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      timer_load  = 1'b0;
      ball_dec    = 1'b0;
      ball_reload = 1'b0;
      score_inc   = 1'b0;
      score_clr   = 1'b0;
      case (state)
         NEWGAME: begin
            if (btn_any) begin
               state_next = PLAY;
               ball_dec   = 1'b1;
            end
         end
         PLAY: begin
            // A miss swallows any same-cycle hit.
            if (miss) begin
               timer_load = 1'b1;
               if (balls_left_dig == 2'd0) begin
                  state_next = OVER;
               end else begin
                  state_next = NEWBALL;
                  ball_dec   = 1'b1;
               end
            end else if (hit) begin
               score_inc = 1'b1;
            end
         end
         NEWBALL: begin
            if (timer_done && btn_any)
               state_next = PLAY;
         end
         OVER: begin
            if (timer_done) begin
               state_next  = NEWGAME;
               score_clr   = 1'b1;
               ball_reload = 1'b1;
            end
         end
         default: state_next = NEWGAME;
      endcase
   end

   // ------------------------------------------------------- frame timer
   // A load wins over a coincident refr_tick, so that tick is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         timer <= '0;
      else if (timer_load)
         timer <= TIMER_W'(TIMER_FRAMES);
      else if (refr_tick && !timer_done)
         timer <= timer - TIMER_W'(1);
   end

   // ------------------------------------------------------ ball counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         balls_left_dig <= 2'(BALLS_INIT);
      else if (ball_reload)
         balls_left_dig <= 2'(BALLS_INIT);
      else if (ball_dec)
         balls_left_dig <= balls_left_dig - 2'd1;
   end

   // ------------------------------------------------------------- score
   bcd2_counter u_score (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (score_clr),
      .inc   (score_inc),
      .dig_1 (score_dig_1),
      .dig_0 (score_dig_0)
   );

   // --------------------------------------------- registered status flags
   // Decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         graph_still    <= 1'b1;
         show_rules     <= 1'b1;
         show_game_over <= 1'b0;
         game_state     <= NEWGAME;
      end else begin
         graph_still    <= (state_next != PLAY);
         show_rules     <= (state_next == NEWGAME);
         show_game_over <= (state_next == OVER);
         game_state     <= state_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Purpose  : Directed self-checking bench for pong_game_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       refr_tick;
   logic [1:0] btn;
   logic       hit;
   logic       miss;
   logic [3:0] score_dig_1;
   logic [3:0] score_dig_0;
   logic [1:0] balls_left_dig;
   logic       graph_still;
   logic       show_rules;
   logic       show_game_over;
   logic [1:0] game_state;

   int compared   = 0;
   int mismatched = 0;

   pong_game_ctrl #(
      .BALLS_INIT   (3),
      .TIMER_FRAMES (120)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .refr_tick      (refr_tick),
      .btn            (btn),
      .hit            (hit),
      .miss           (miss),
      .score_dig_1    (score_dig_1),
      .score_dig_0    (score_dig_0),
      .balls_left_dig (balls_left_dig),
      .graph_still    (graph_still),
      .show_rules     (show_rules),
      .show_game_over (show_game_over),
      .game_state     (game_state)
   );

   always #5 clk = ~clk;

   // One clock edge, then settle 1 time unit before anything is sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         refr_tick = 1'b1;
         tick();
         refr_tick = 1'b0;
         tick();
      end
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         hit = 1'b1;
         tick();
         hit = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; refr_tick = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0;
      tick(); tick();
      check("reset_state",   32'(game_state), 32'd0);
      check("reset_d1",      32'(score_dig_1), 32'd0);
      check("reset_d0",      32'(score_dig_0), 32'd0);
      check("reset_balls",   32'(balls_left_dig), 32'd3);
      check("reset_still",   32'(graph_still), 32'd1);
      check("reset_rules",   32'(show_rules), 32'd1);
      check("reset_over",    32'(show_game_over), 32'd0);

      @(negedge clk) rst_n = 1'b1;
      repeat (10) tick();
      check("idle_state", 32'(game_state), 32'd0);
      check("idle_balls", 32'(balls_left_dig), 32'd3);
      check("idle_still", 32'(graph_still), 32'd1);
      check("idle_rules", 32'(show_rules), 32'd1);

      // hit/miss in NEWGAME are ignored
      hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
      check("ng_hit_ign_d0", 32'(score_dig_0), 32'd0);
      check("ng_miss_ign_st", 32'(game_state), 32'd0);

      // start game
      btn = 2'b01; tick(); btn = 2'b00;
      check("start_state", 32'(game_state), 32'd1);
      check("start_balls", 32'(balls_left_dig), 32'd2);
      check("start_still", 32'(graph_still), 32'd0);
      check("start_rules", 32'(show_rules), 32'd0);

      hits(10);
      check("s10", {score_dig_1, score_dig_0}, 32'h10);
      hits(2);
      check("s12", {score_dig_1, score_dig_0}, 32'h12);
      hits(87);
      check("s99", {score_dig_1, score_dig_0}, 32'h99);
      hits(1);
      check("s00_wrap", {score_dig_1, score_dig_0}, 32'h00);
      hits(5);
      check("s05", {score_dig_1, score_dig_0}, 32'h05);

      // miss beats same-cycle hit
      miss = 1'b1; hit = 1'b1; tick(); miss = 1'b0; hit = 1'b0;
      check("mh_score", {score_dig_1, score_dig_0}, 32'h05);
      check("mh_state", 32'(game_state), 32'd2);
      check("mh_balls", 32'(balls_left_dig), 32'd1);
      check("mh_still", 32'(graph_still), 32'd1);

      // hit in NEWBALL ignored
      hits(1);
      check("nb_hit_ign", {score_dig_1, score_dig_0}, 32'h05);

      // btn held during the hold time is ignored
      btn = 2'b01;
      frames(119);
      check("nb_119_state", 32'(game_state), 32'd2);
      refr_tick = 1'b1; tick(); refr_tick = 1'b0;
      check("nb_120_state", 32'(game_state), 32'd2);
      tick();
      check("nb_play_state", 32'(game_state), 32'd1);
      check("nb_play_still", 32'(graph_still), 32'd0);
      btn = 2'b00;

      // last ball: 1 -> 0, then back to play with btn
      miss = 1'b1; tick(); miss = 1'b0;
      check("m2_state", 32'(game_state), 32'd2);
      check("m2_balls", 32'(balls_left_dig), 32'd0);
      frames(120);
      check("m2_wait_state", 32'(game_state), 32'd2);
      btn = 2'b10; tick(); btn = 2'b00;
      check("m2_play_state", 32'(game_state), 32'd1);

      // miss with no balls left -> OVER; coincident refr_tick not counted
      miss = 1'b1; refr_tick = 1'b1; tick(); miss = 1'b0; refr_tick = 1'b0;
      check("over_state", 32'(game_state), 32'd3);
      check("over_show", 32'(show_game_over), 32'd1);
      check("over_still", 32'(graph_still), 32'd1);
      frames(119);
      check("over_119_state", 32'(game_state), 32'd3);
      frames(1);
      check("over_ng_state", 32'(game_state), 32'd0);
      check("over_ng_score", {score_dig_1, score_dig_0}, 32'h00);
      check("over_ng_balls", 32'(balls_left_dig), 32'd3);
      check("over_ng_rules", 32'(show_rules), 32'd1);
      check("over_ng_show", 32'(show_game_over), 32'd0);

      // mid-play asynchronous reset
      btn = 2'b11; tick(); btn = 2'b00;
      hits(47);
      check("pre_rst_score", {score_dig_1, score_dig_0}, 32'h47);
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", 32'(game_state), 32'd0);
      check("arst_score", {score_dig_1, score_dig_0}, 32'h00);
      check("arst_balls", 32'(balls_left_dig), 32'd3);
      check("arst_still", 32'(graph_still), 32'd1);
      check("arst_rules", 32'(show_rules), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      btn = 2'b01; tick(); btn = 2'b00;
      hits(1);
      check("post_rst_score", {score_dig_1, score_dig_0}, 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-control block that produces the score and balls-left digits consumed by the pong text overlay, and sequences the game through new-game, serve, play and game-over phases. Sits between the graphics engine (which reports `hit`/`miss` events and holds the ball while `graph_still` is high) and the text overlay (which reads `score_dig_1`, `score_dig_0` and `balls_left_dig`, and selects the rules or game-over region from `show_rules`/`show_game_over`). All outputs are registered.

## Interface
- `BALLS_INIT`, 3: balls per game; legal range 1..3 (2-bit digit).
- `TIMER_FRAMES`, 120: frame ticks of hold time after a miss or game over (2 s at 60 Hz); legal range 1..255.
- `clk` input 1: single system clock (pixel-clock domain).
- `rst_n` input 1: reset, asynchronous, active-low.
- `refr_tick` input 1: one-cycle pulse per frame (start of vertical blank).
- `btn` input 2: paddle buttons; already debounced and synchronous to `clk`; level-sensitive.
- `hit` input 1: one-cycle pulse; ball struck paddle.
- `miss` input 1: one-cycle pulse; ball passed paddle.
- `score_dig_1` output 4: BCD tens digit.
- `score_dig_0` output 4: BCD units digit.
- `balls_left_dig` output 2: balls remaining.
- `graph_still` output 1: 1 = ball frozen/hidden; graphics ignores motion.
- `show_rules` output 1: high in NEWGAME.
- `show_game_over` output 1: high in OVER.
- `game_state` output 2: encoded current state (debug/top-level mux).

## Operation
- States: NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3.
- NEWGAME: wait for `btn != 0`; then go to PLAY and decrement `balls_left_dig`.
- PLAY: a `miss` with `balls_left_dig == 0` goes to OVER and loads the timer. A `miss` with `balls_left_dig > 0` goes to NEWBALL, decrements the ball count and loads the timer. A `hit` without `miss` increments the score.
- NEWBALL: once the timer has expired and `btn != 0`, go to PLAY.
- OVER: once the timer has expired, go to NEWGAME.
- On the OVER→NEWGAME transition, the score clears to 00 and the ball count reloads to `BALLS_INIT`.
- Score:
  - two-digit BCD increment;
  - units 9 rolls to 0 and carries into tens;
  - 99 wraps to 00 with no flag;
  - digits never hold values above 9.
- Timer:
  - `$clog2(TIMER_FRAMES+1)`-bit down-counter;
  - "load" sets it to `TIMER_FRAMES`;
  - decrements on `refr_tick` while non-zero;
  - "expired" means the count equals 0.
- Priority:
  - `miss` beats a same-cycle `hit`; that `hit` is dropped;
  - `hit`/`miss` outside PLAY are ignored;
  - `btn` held while the timer is non-zero is ignored; a still-held `btn` is accepted in the first cycle after expiry.
- `graph_still` = (state != PLAY). `show_rules` = (state == NEWGAME). `show_game_over` = (state == OVER).

## Timing
- Reset values:
  - state = NEWGAME;
  - score = 00;
  - `balls_left_dig` = `BALLS_INIT`;
  - timer = 0;
  - `graph_still` = 1, `show_rules` = 1, `show_game_over` = 0, `game_state` = 0.
- All outputs update on the `clk` edge after the causing input; latency is 1 cycle.
- A `hit` sampled at edge n gives a new score visible after edge n.
- A `miss` at edge n changes state, ball count and timer load on the same edge. `graph_still` rises after edge n.
- Expiry: `TIMER_FRAMES` `refr_tick` pulses after the load. A `refr_tick` coincident with the load edge is not counted.
- A `btn` press in NEWGAME is accepted in the same cycle it is first sampled; there is no edge detection.
- Reset assertion mid-game forces reset values immediately (asynchronous). Release must be synchronised externally to `clk`.

## Structure
- `pong_pkg`: `game_state_t` enum (2-bit, encodings above), `bcd_digit_t` (logic [3:0]), `DIGIT_MAX = 4'd9`.
- One sub-module, `bcd2_counter`: two-digit BCD counter with `inc` and synchronous `clr` inputs, async active-low reset, 99→00 wrap.
- FSM, ball counter and frame timer live in `pong_game_ctrl`.

## Test plan
- Reset, then idle for 10 cycles → state 0, digits 0/0, balls 3, `graph_still` 1, `show_rules` 1.
- `btn = 2'b01` for 1 cycle → next cycle state PLAY, balls 2, `graph_still` 0. Then 12 `hit` pulses → digits 1/2. Then 88 more pulses (100 total) → 0/0.
- `miss` and `hit` in the same cycle with score 0/5 → score stays 0/5, state NEWBALL, balls 1.
- In NEWBALL:
  - `btn` held through 119 `refr_tick` pulses → stays NEWBALL;
  - after the 120th pulse → PLAY one cycle later.
- `miss` with balls 0 → OVER and `show_game_over` 1. 120 `refr_tick` pulses later → NEWGAME, score 0/0, balls 3.
- Assert `rst_n` low mid-PLAY with score 4/7 → outputs take reset values without waiting for a clock edge. After release, the first `hit` in PLAY → 0/1.
